// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file, NUM_RD async reads, two byte-enabled write ports
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W/8-1:0]      wr0_be,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W/8-1:0]      wr1_be,
    input  logic [DATA_W-1:0]        wr1_data,
    output logic                     conflict
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr0_ok;
    logic              wr1_ok;
    logic [NB-1:0]     overlap;

    // A write aimed at the hard-wired zero entry is treated as no write at all.
    assign wr0_ok  = wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
    assign wr1_ok  = wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);
    assign overlap = (wr0_ok && wr1_ok && wr0_addr == wr1_addr) ? (wr0_be & wr1_be) : '0;

    // Port 1 is assigned last so it wins on overlapping bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            conflict <= 1'b0;
        end else begin
            conflict <= |overlap;
            for (int b = 0; b < NB; b++) begin
                if (wr0_ok && wr0_be[b]) begin
                    mem[wr0_addr][b*8 +: 8] <= wr0_data[b*8 +: 8];
                end
                if (wr1_ok && wr1_be[b]) begin
                    mem[wr1_addr][b*8 +: 8] <= wr1_data[b*8 +: 8];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem[addr];
            if (BYPASS != 0) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr0_en && wr0_be[b] && wr0_addr == addr) begin
                        data[b*8 +: 8] = wr0_data[b*8 +: 8];
                    end
                    if (wr1_en && wr1_be[b] && wr1_addr == addr) begin
                        data[b*8 +: 8] = wr1_data[b*8 +: 8];
                    end
                end
            end
            if (reset || (ZERO_REG != 0 && addr == '0)) begin
                data = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - checks two reg_file_mp configurations against an array-based model
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic reset;

    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic        a_wr0_en, a_wr1_en;
    logic [4:0]  a_wr0_addr, a_wr1_addr;
    logic [3:0]  a_wr0_be, a_wr1_be;
    logic [31:0] a_wr0_data, a_wr1_data;
    logic        a_conflict;

    logic [11:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic         b_wr0_en, b_wr1_en;
    logic [3:0]   b_wr0_addr, b_wr1_addr;
    logic [7:0]   b_wr0_be, b_wr1_be;
    logic [63:0]  b_wr0_data, b_wr1_data;
    logic         b_conflict;

    logic [31:0] ma [32];
    logic [63:0] mb [16];
    logic        exp_ca, exp_cb;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_mp dut_a (
        .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .wr0_en(a_wr0_en), .wr0_addr(a_wr0_addr), .wr0_be(a_wr0_be), .wr0_data(a_wr0_data),
        .wr1_en(a_wr1_en), .wr1_addr(a_wr1_addr), .wr1_be(a_wr1_be), .wr1_data(a_wr1_data),
        .conflict(a_conflict)
    );

    reg_file_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_be(b_wr0_be), .wr0_data(b_wr0_data),
        .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_be(b_wr1_be), .wr1_data(b_wr1_data),
        .conflict(b_conflict)
    );

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] be,
                                          input logic [63:0] d);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_a(input logic [4:0] x);
        logic [63:0] v;
        v = {32'h0, ma[x]};
        if (a_wr0_en && a_wr0_addr == x) v = merge(v, {4'h0, a_wr0_be}, {32'h0, a_wr0_data});
        if (a_wr1_en && a_wr1_addr == x) v = merge(v, {4'h0, a_wr1_be}, {32'h0, a_wr1_data});
        if (reset || x == 5'd0) v = '0;
        return v[31:0];
    endfunction

    function automatic logic [63:0] exp_b(input logic [3:0] x);
        return reset ? 64'h0 : mb[x];
    endfunction

    function automatic logic [63:0] pat(input int i);
        return {8{8'(i)}} ^ 64'hA5C3_0F96_5A3C_F069;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ma[i] = '0;
        for (int i = 0; i < 16; i++) mb[i] = '0;
        exp_ca = 1'b0;
        exp_cb = 1'b0;
    endtask

    task automatic model_edge();
        logic [63:0] t;
        if (reset) begin
            model_clear();
        end else begin
            exp_ca = a_wr0_en && a_wr1_en && a_wr0_addr == a_wr1_addr && a_wr0_addr != 5'd0
                     && (a_wr0_be & a_wr1_be) != 4'h0;
            exp_cb = b_wr0_en && b_wr1_en && b_wr0_addr == b_wr1_addr
                     && (b_wr0_be & b_wr1_be) != 8'h0;
            if (a_wr0_en && a_wr0_addr != 5'd0) begin
                t = merge({32'h0, ma[a_wr0_addr]}, {4'h0, a_wr0_be}, {32'h0, a_wr0_data});
                ma[a_wr0_addr] = t[31:0];
            end
            if (a_wr1_en && a_wr1_addr != 5'd0) begin
                t = merge({32'h0, ma[a_wr1_addr]}, {4'h0, a_wr1_be}, {32'h0, a_wr1_data});
                ma[a_wr1_addr] = t[31:0];
            end
            if (b_wr0_en) mb[b_wr0_addr] = merge(mb[b_wr0_addr], b_wr0_be, b_wr0_data);
            if (b_wr1_en) mb[b_wr1_addr] = merge(mb[b_wr1_addr], b_wr1_be, b_wr1_data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        a_wr0_en = 1'b0; a_wr0_addr = '0; a_wr0_be = '0; a_wr0_data = '0;
        a_wr1_en = 1'b0; a_wr1_addr = '0; a_wr1_be = '0; a_wr1_data = '0;
        b_wr0_en = 1'b0; b_wr0_addr = '0; b_wr0_be = '0; b_wr0_data = '0;
        b_wr1_en = 1'b0; b_wr1_addr = '0; b_wr1_be = '0; b_wr1_data = '0;
    endtask

    task automatic check_reads();
        for (int k = 0; k < 2; k++)
            check("rd_a", 64'(a_rd_data[k*32 +: 32]), 64'(exp_a(a_rd_addr[k*5 +: 5])));
        for (int k = 0; k < 3; k++)
            check("rd_b", b_rd_data[k*64 +: 64], exp_b(b_rd_addr[k*4 +: 4]));
    endtask

    task automatic check_conflicts();
        check("conflict_a", 64'(a_conflict), 64'(exp_ca));
        check("conflict_b", 64'(b_conflict), 64'(exp_cb));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        a_rd_addr = '0;
        b_rd_addr = '0;
        model_clear();
        #2;
        check_reads();
        check_conflicts();
        tick();
        tick();
        reset = 1'b0;

        // Colliding write to r5 so conflict is high when reset hits mid-cycle.
        a_wr0_en = 1'b1; a_wr0_addr = 5'd5; a_wr0_be = 4'hF; a_wr0_data = 32'hDEADBEEF;
        a_wr1_en = 1'b1; a_wr1_addr = 5'd5; a_wr1_be = 4'h1; a_wr1_data = 32'hDEADBEEF;
        tick();
        idle();
        check("collide_r5_conflict", 64'(a_conflict), 64'h1);
        a_rd_addr = {5'd5, 5'd5};
        #1;
        check("r5_written", 64'(a_rd_data[31:0]), 64'hDEADBEEF);
        reset = 1'b1;
        model_clear();
        #1;
        check("async_reset_rd", 64'(a_rd_data[31:0]), 64'h0);
        check("async_reset_conflict", 64'(a_conflict), 64'h0);
        a_wr0_en = 1'b1; a_wr0_addr = 5'd5; a_wr0_be = 4'hF; a_wr0_data = 32'h12345678;
        #1;
        check_reads();
        tick();
        idle();
        reset = 1'b0;
        #1;
        check("write_in_reset_dropped", 64'(a_rd_data[31:0]), 64'h0);

        a_wr0_en = 1'b1; a_wr0_addr = 5'd3; a_wr0_be = 4'hF; a_wr0_data = 32'h11223344;
        tick();
        a_wr0_be = 4'b0101; a_wr0_data = 32'hAABBCCDD;
        tick();
        idle();
        a_rd_addr = {5'd3, 5'd3};
        #1;
        check("be_write_p0", 64'(a_rd_data[31:0]), 64'h11BB33DD);
        check("be_write_p1", 64'(a_rd_data[63:32]), 64'h11BB33DD);

        a_wr0_en = 1'b1; a_wr0_addr = 5'd7; a_wr0_be = 4'hF;    a_wr0_data = 32'h00000001;
        a_wr1_en = 1'b1; a_wr1_addr = 5'd7; a_wr1_be = 4'b1100; a_wr1_data = 32'hFFFF0000;
        tick();
        idle();
        check("collision_conflict_set", 64'(a_conflict), 64'h1);
        tick();
        check("collision_conflict_clear", 64'(a_conflict), 64'h0);
        a_rd_addr = {5'd3, 5'd7};
        #1;
        check("collision_value", 64'(a_rd_data[31:0]), 64'hFFFF0001);

        a_rd_addr = {5'd7, 5'd0};
        a_wr0_en = 1'b1; a_wr0_addr = 5'd0; a_wr0_be = 4'hF; a_wr0_data = 32'h87654321;
        a_wr1_en = 1'b1; a_wr1_addr = 5'd0; a_wr1_be = 4'hF; a_wr1_data = 32'h12345678;
        #1;
        check("zero_reg_bypass", 64'(a_rd_data[31:0]), 64'h0);
        tick();
        idle();
        check("zero_reg_no_conflict", 64'(a_conflict), 64'h0);
        #1;
        check("zero_reg_after", 64'(a_rd_data[31:0]), 64'h0);

        a_rd_addr = {5'd9, 5'd7};
        b_rd_addr = {4'd0, 4'd0, 4'd9};
        a_wr0_en = 1'b1; a_wr0_addr = 5'd9; a_wr0_be = 4'hF; a_wr0_data = 32'hCAFEF00D;
        b_wr0_en = 1'b1; b_wr0_addr = 4'd9; b_wr0_be = 8'hFF; b_wr0_data = 64'hCAFEF00D;
        #1;
        check("bypass_on", 64'(a_rd_data[63:32]), 64'hCAFEF00D);
        check("bypass_off_before", b_rd_data[63:0], 64'h0);
        check_reads();
        tick();
        idle();
        #1;
        check("bypass_off_after", b_rd_data[63:0], 64'hCAFEF00D);
        check("bypass_on_after", 64'(a_rd_data[63:32]), 64'hCAFEF00D);

        for (int i = 0; i < 8; i++) begin
            b_wr0_en = 1'b1; b_wr0_addr = 4'(2*i);   b_wr0_be = 8'hFF; b_wr0_data = pat(2*i);
            b_wr1_en = 1'b1; b_wr1_addr = 4'(2*i+1); b_wr1_be = 8'hFF; b_wr1_data = pat(2*i+1);
            tick();
        end
        idle();
        for (int j = 0; j < 16; j++) begin
            b_rd_addr = {4'(j+2), 4'(j+1), 4'(j)};
            #1;
            for (int k = 0; k < 3; k++)
                check("sweep_rd", b_rd_data[k*64 +: 64], pat((j + k) % 16));
            tick();
        end

        repeat (300) begin
            a_wr0_en = 1'($urandom); a_wr0_addr = 5'($urandom_range(0, 7));
            a_wr0_be = 4'($urandom); a_wr0_data = $urandom;
            a_wr1_en = 1'($urandom); a_wr1_addr = 5'($urandom_range(0, 7));
            a_wr1_be = 4'($urandom); a_wr1_data = $urandom;
            a_rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            b_wr0_en = 1'($urandom); b_wr0_addr = 4'($urandom_range(0, 15));
            b_wr0_be = 8'($urandom); b_wr0_data = {$urandom, $urandom};
            b_wr1_en = 1'($urandom); b_wr1_addr = 4'($urandom_range(0, 15));
            b_wr1_be = 8'($urandom); b_wr1_data = {$urandom, $urandom};
            b_rd_addr = 12'($urandom);
            #1;
            check_reads();
            tick();
            check_conflicts();
        end
        idle();
        #1;
        check_reads();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
